// File: rtl/register_file.sv
// rtl/register_file.sv - 64x16 register file, two write / three read ports, sweep clear
//
// Purpose:
//   General-purpose register file with two write ports and three registered
//   read ports. Reads are write-first: a read sampled on the same edge as a
//   committed write to the same address returns the new data. A clear request
//   starts a sweep that zeroes one entry per clock, lowest index first, while
//   reads keep working and external writes are dropped.
//
// Ports:
//   clock                          sole clock, rising edge
//   reset                          asynchronous, active-high reset
//   reg_rd1, reg_rd2, reg_rd3      read addresses, sampled on the edge
//   reg_rd1_out .. reg_rd3_out     registered read data (one-cycle latency)
//   reg_wr1, reg_wr2               write addresses
//   reg_wr1_data, reg_wr2_data     write data
//   reg_wr1_enable, reg_wr2_enable write strobes (port 2 wins on equal address)
//   clear_req                      request to zero the whole file
//   busy                           high while a clear sweep is in progress

module register_file #(
  parameter int NREGS = 64,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       reg_rd1,
  input  logic [5:0]       reg_rd2,
  input  logic [5:0]       reg_rd3,
  output logic [WIDTH-1:0] reg_rd1_out,
  output logic [WIDTH-1:0] reg_rd2_out,
  output logic [WIDTH-1:0] reg_rd3_out,
  input  logic [5:0]       reg_wr1,
  input  logic [5:0]       reg_wr2,
  input  logic [WIDTH-1:0] reg_wr1_data,
  input  logic [WIDTH-1:0] reg_wr2_data,
  input  logic             reg_wr1_enable,
  input  logic             reg_wr2_enable,
  input  logic             clear_req,
  output logic             busy
);

  localparam int AW = 6;
  localparam logic [AW-1:0] LAST_INDEX = AW'(NREGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   index;
  logic [WIDTH-1:0] regs [NREGS];

  logic            wr1_commit;
  logic            wr2_commit;
  logic [AW-1:0]   rd_addr [3];
  logic [WIDTH-1:0] rd_next [3];

  // Writes only land in IDLE, and not on the edge that enters CLEAR, so the
  // sweep never races with an external write into an already-zeroed entry.
  assign wr1_commit = reg_wr1_enable && (state == IDLE) && !clear_req;
  assign wr2_commit = reg_wr2_enable && (state == IDLE) && !clear_req;

  assign rd_addr[0] = reg_rd1;
  assign rd_addr[1] = reg_rd2;
  assign rd_addr[2] = reg_rd3;

  // ---------------------------------------------------------------------------
  // FSM: state register and sweep index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (clear_req) begin
            index <= '0;
          end
        end
        CLEAR: begin
          // Wraps back to 0 on the edge that zeroes the last entry.
          if (index == LAST_INDEX) begin
            index <= '0;
          end else begin
            index <= index + AW'(1);
          end
        end
        default: index <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        // clear_req is ignored here; a held request re-enters from IDLE.
        if (index == LAST_INDEX) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    if (state == CLEAR) begin
      busy = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[index] <= '0;
    end else begin
      // Port 2 is assigned last so it wins on equal addresses.
      if (wr1_commit) begin
        regs[reg_wr1] <= reg_wr1_data;
      end
      if (wr2_commit) begin
        regs[reg_wr2] <= reg_wr2_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: value each entry will hold after this edge (write-first)
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_next[p] = regs[rd_addr[p]];
      if ((state == CLEAR) && (rd_addr[p] == index)) begin
        rd_next[p] = '0;
      end
      if (wr1_commit && (rd_addr[p] == reg_wr1)) begin
        rd_next[p] = reg_wr1_data;
      end
      if (wr2_commit && (rd_addr[p] == reg_wr2)) begin
        rd_next[p] = reg_wr2_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_rd1_out <= '0;
      reg_rd2_out <= '0;
      reg_rd3_out <= '0;
    end else begin
      reg_rd1_out <= rd_next[0];
      reg_rd2_out <= rd_next[1];
      reg_rd3_out <= rd_next[2];
    end
  end

endmodule
